wired_lsu_arbiter: RTL and testbench
====================================

WIRED_LSU_ARBITER -- requirements
Module: wired_lsu_arbiter

Interface
REQ-001 Parameter REQ_CNT, default 2: number of requesters sharing one LSU request/response port.
REQ-002 Parameter OUTSTANDING, default 4 (power of two): maximum accepted LSU requests whose responses have not yet returned.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 flush_i  input  1  backend pipeline flush; discards all arbiter state.
REQ-006 req_valid_i  input  REQ_CNT  per-requester request valid.
REQ-007 req_ready_o  output  REQ_CNT  per-requester request accepted this cycle.
REQ-008 req_i  input  REQ_CNT x $bits(iq_lsu_req_t)  per-requester request payload.
REQ-009 lsu_req_valid_o  output  1  request valid toward the LSU.
REQ-010 lsu_req_ready_i  input  1  LSU accepts the request.
REQ-011 lsu_req_o  output  $bits(iq_lsu_req_t)  request payload of the granted requester.
REQ-012 lsu_resp_valid_i  input  1  LSU response valid.
REQ-013 lsu_resp_ready_o  output  1  arbiter accepts the LSU response.
REQ-014 lsu_resp_i  input  $bits(iq_lsu_resp_t)  LSU response payload.
REQ-015 resp_valid_o  output  REQ_CNT  response valid, one-hot to its originating requester.
REQ-016 resp_ready_i  input  REQ_CNT  per-requester response ready.
REQ-017 resp_o  output  $bits(iq_lsu_resp_t)  response payload, broadcast to all requesters, equal to lsu_resp_i.
REQ-018 busy_o  output  1  high when the tag FIFO is non-empty or the FSM is not IDLE.

Function
REQ-019 Arbitration is round-robin: grant the lowest index at or above rr_q (wrapping mod REQ_CNT) with req_valid_i set; rr_q becomes grant+1 mod REQ_CNT on each LSU request handshake, with 0 following REQ_CNT-1.
REQ-020 lsu_req_o equals req_i[grant], lsu_req_valid_o equals req_valid_i[grant] gated by issue enable, and req_ready_o[grant] equals lsu_req_ready_i gated by issue enable; all other req_ready_o bits are 0.
REQ-021 Issue enable is 0 when the tag FIFO holds OUTSTANDING entries, when the FSM is in DRAIN, or when flush_i=1.
REQ-022 FSM states: IDLE, HOLD, DRAIN; reset and flush state is IDLE.
REQ-023 In IDLE, lsu_req_valid_o=1 with lsu_req_ready_i=0 moves the FSM to HOLD and latches the grant index; a handshake with lsu_req_o.dbar=1 moves it to DRAIN; any other handshake leaves it in IDLE.
REQ-024 In HOLD, the grant is fixed to the latched index regardless of other requesters; a handshake returns the FSM to IDLE, or to DRAIN if dbar=1.
REQ-025 In DRAIN, no request is issued; the FSM returns to IDLE in the cycle after the tag FIFO becomes empty.
REQ-026 On each LSU request handshake, the grant index is pushed into the tag FIFO (depth OUTSTANDING; wrap-around read and write pointers plus a count of PTR+1 bits).
REQ-027 When the FIFO is non-empty, resp_valid_o[head]=lsu_resp_valid_i and lsu_resp_ready_o=resp_ready_i[head]; the head is popped on the LSU response handshake.
REQ-028 When the FIFO is empty, lsu_resp_ready_o=1, resp_valid_o=0, and any incoming response is silently discarded (this sinks stale post-flush responses).
REQ-029 A push and a pop in the same cycle leave the count unchanged; a push when full is impossible by REQ-021, and a pop when empty is impossible by REQ-028.
REQ-030 Latency is zero in both directions: the request path and the response path are combinational through the arbiter.

Reset
REQ-031 On rst=1 or flush_i=1 at a clock edge: FSM goes to IDLE, rr_q=0, FIFO pointers and count become 0, and the latched grant becomes 0.
REQ-032 Outputs during and immediately after reset: lsu_req_valid_o=0, req_ready_o=0, resp_valid_o=0, lsu_resp_ready_o=1, busy_o=0.
REQ-033 A flush in the same cycle as a request handshake or response handshake discards that transaction; the FIFO is not pushed or popped.

Verification
REQ-034 Both requesters valid every cycle, lsu_req_ready_i=1, responses returned in order -> grants alternate 0,1,0,1, and each response reaches resp_valid_o of its issuer.
REQ-035 Requester 0 valid, lsu_req_ready_i=0 for 3 cycles, then requester 1 also raises valid -> lsu_req_o stays requester 0's payload until handshake; requester 1 is granted next.
REQ-036 With OUTSTANDING=4, issue 4 requests with no responses -> lsu_req_valid_o=0 on the 5th; one response handshake -> issue resumes the following cycle.
REQ-037 Issue 2 loads, then a dbar request -> no further lsu_req_valid_o until all 3 responses pop, then IDLE and issue resumes the next cycle.
REQ-038 Issue 3 requests, assert flush_i with a response valid in the same cycle -> response dropped, busy_o=0 next cycle, the next 3 stale responses are absorbed with lsu_resp_ready_o=1 and resp_valid_o=0.
REQ-039 Stall resp_ready_i of the head requester while the other requester is ready -> lsu_resp_ready_o=0 and the head is not popped (in-order backpressure).

Source files
------------

// File: rtl/wired_lsu_arbiter.sv
// rtl/wired_lsu_arbiter.sv - round-robin arbiter sharing one LSU port, with in-order response routing
package wired_lsu_pkg;
    typedef struct packed {
        logic        dbar;
        logic        store;
        logic [15:0] addr;
    } iq_lsu_req_t;

    typedef struct packed {
        logic        err;
        logic [15:0] rdata;
    } iq_lsu_resp_t;

    localparam int REQ_W  = $bits(iq_lsu_req_t);
    localparam int RESP_W = $bits(iq_lsu_resp_t);
endpackage

module wired_lsu_arbiter
    import wired_lsu_pkg::*;
#(
    parameter int REQ_CNT     = 2,
    parameter int OUTSTANDING = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush_i,
    input  logic [REQ_CNT-1:0]       req_valid_i,
    output logic [REQ_CNT-1:0]       req_ready_o,
    input  logic [REQ_CNT*REQ_W-1:0] req_i,
    output logic                     lsu_req_valid_o,
    input  logic                     lsu_req_ready_i,
    output logic [REQ_W-1:0]         lsu_req_o,
    input  logic                     lsu_resp_valid_i,
    output logic                     lsu_resp_ready_o,
    input  logic [RESP_W-1:0]        lsu_resp_i,
    output logic [REQ_CNT-1:0]       resp_valid_o,
    input  logic [REQ_CNT-1:0]       resp_ready_i,
    output logic [RESP_W-1:0]        resp_o,
    output logic                     busy_o
);
    localparam int TAG_W = (REQ_CNT > 1) ? $clog2(REQ_CNT) : 1;
    localparam int PTR_W = $clog2(OUTSTANDING);

    typedef enum logic [1:0] {IDLE, HOLD, DRAIN} state_t;

    state_t            state_q, state_d;
    logic [TAG_W-1:0]  rr_q, rr_d, hold_q, hold_d;
    logic [TAG_W-1:0]  grant, cand, head;
    logic [TAG_W:0]    sum;
    logic              found;
    logic [TAG_W-1:0]  tag_q [OUTSTANDING];
    logic [PTR_W-1:0]  wptr_q, rptr_q;
    logic [PTR_W:0]    cnt_q, cnt_d;
    logic              kill, fifo_empty, fifo_full, issue_en, req_hs, push, pop;
    iq_lsu_req_t       gnt_req;

    assign kill       = rst | flush_i;
    assign fifo_empty = (cnt_q == '0);
    assign fifo_full  = (cnt_q == (PTR_W+1)'(OUTSTANDING));
    assign issue_en   = !fifo_full && (state_q != DRAIN) && !kill;

    // Round-robin search starting at rr_q; HOLD pins the grant so a stalled payload stays stable.
    always_comb begin
        grant = rr_q;
        found = 1'b0;
        sum   = '0;
        cand  = '0;
        for (int i = 0; i < REQ_CNT; i++) begin
            sum = {1'b0, rr_q} + (TAG_W+1)'(i);
            if (sum >= (TAG_W+1)'(REQ_CNT)) begin
                sum = sum - (TAG_W+1)'(REQ_CNT);
            end
            cand = sum[TAG_W-1:0];
            if (!found && req_valid_i[cand]) begin
                grant = cand;
                found = 1'b1;
            end
        end
        if (state_q == HOLD) begin
            grant = hold_q;
        end
    end

    assign gnt_req         = iq_lsu_req_t'(req_i[int'(grant)*REQ_W +: REQ_W]);
    assign lsu_req_o       = gnt_req;
    assign lsu_req_valid_o = req_valid_i[grant] & issue_en;
    assign req_hs          = lsu_req_valid_o & lsu_req_ready_i;
    assign push            = req_hs;

    always_comb begin
        req_ready_o        = '0;
        req_ready_o[grant] = lsu_req_ready_i & issue_en;
    end

    assign head   = tag_q[rptr_q];
    assign resp_o = lsu_resp_i;

    // An empty FIFO (or a flush) sinks whatever the LSU returns.
    always_comb begin
        resp_valid_o = '0;
        if (!fifo_empty && !kill) begin
            resp_valid_o[head] = lsu_resp_valid_i;
        end
    end

    assign lsu_resp_ready_o = (fifo_empty || kill) ? 1'b1 : resp_ready_i[head];
    assign pop              = !fifo_empty && !kill && lsu_resp_valid_i && lsu_resp_ready_o;

    always_comb begin
        cnt_d = cnt_q;
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        rr_d    = rr_q;
        if (req_hs) begin
            rr_d = (grant == TAG_W'(REQ_CNT - 1)) ? '0 : grant + 1'b1;
        end
        case (state_q)
            IDLE: begin
                if (req_hs) begin
                    state_d = gnt_req.dbar ? DRAIN : IDLE;
                end else if (lsu_req_valid_o) begin
                    state_d = HOLD;
                    hold_d  = grant;
                end
            end
            HOLD: begin
                if (req_hs) begin
                    state_d = gnt_req.dbar ? DRAIN : IDLE;
                end
            end
            DRAIN: begin
                if (cnt_d == '0) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (kill) begin
            state_q <= IDLE;
            rr_q    <= '0;
            hold_q  <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            hold_q  <= hold_d;
            cnt_q   <= cnt_d;
            if (push) begin
                wptr_q <= wptr_q + 1'b1;
            end
            if (pop) begin
                rptr_q <= rptr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            tag_q[wptr_q] <= grant;
        end
    end

    assign busy_o = !rst && (!fifo_empty || (state_q != IDLE));

endmodule

// File: tb/tb_wired_lsu_arbiter.sv
// tb/tb_wired_lsu_arbiter.sv - directed self-checking bench for wired_lsu_arbiter
module tb_wired_lsu_arbiter;
    import wired_lsu_pkg::*;

    logic              clk = 1'b0;
    logic              rst;
    logic              flush_i;
    logic [1:0]        req_valid_i;
    logic [1:0]        req_ready_o;
    logic [2*REQ_W-1:0] req_i;
    logic              lsu_req_valid_o;
    logic              lsu_req_ready_i;
    logic [REQ_W-1:0]  lsu_req_o;
    logic              lsu_resp_valid_i;
    logic              lsu_resp_ready_o;
    logic [RESP_W-1:0] lsu_resp_i;
    logic [1:0]        resp_valid_o;
    logic [1:0]        resp_ready_i;
    logic [RESP_W-1:0] resp_o;
    logic              busy_o;

    int tests  = 0;
    int failed = 0;

    wired_lsu_arbiter #(.REQ_CNT(2), .OUTSTANDING(4)) dut (
        .clk              (clk),
        .rst              (rst),
        .flush_i          (flush_i),
        .req_valid_i      (req_valid_i),
        .req_ready_o      (req_ready_o),
        .req_i            (req_i),
        .lsu_req_valid_o  (lsu_req_valid_o),
        .lsu_req_ready_i  (lsu_req_ready_i),
        .lsu_req_o        (lsu_req_o),
        .lsu_resp_valid_i (lsu_resp_valid_i),
        .lsu_resp_ready_o (lsu_resp_ready_o),
        .lsu_resp_i       (lsu_resp_i),
        .resp_valid_o     (resp_valid_o),
        .resp_ready_i     (resp_ready_i),
        .resp_o           (resp_o),
        .busy_o           (busy_o)
    );

    always #5 clk = ~clk;

    function automatic logic [REQ_W-1:0] mk(input logic dbar, input logic [15:0] addr);
        return {dbar, 1'b0, addr};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    localparam logic [REQ_W-1:0] R0  = {1'b0, 1'b0, 16'h0A00};
    localparam logic [REQ_W-1:0] R1  = {1'b0, 1'b0, 16'h0B01};
    localparam logic [REQ_W-1:0] R1B = {1'b1, 1'b0, 16'h0BDB};

    initial begin
        rst = 1'b1; flush_i = 1'b0; req_valid_i = 2'b00; lsu_req_ready_i = 1'b0;
        lsu_resp_valid_i = 1'b0; resp_ready_i = 2'b00;
        req_i = {mk(1'b0, 16'h0B01), mk(1'b0, 16'h0A00)};
        lsu_resp_i = 17'h0_1234;
        tick;
        chk("rst_lsu_valid", 32'(lsu_req_valid_o), 32'd0);
        chk("rst_req_ready", 32'(req_ready_o), 32'd0);
        chk("rst_resp_valid", 32'(resp_valid_o), 32'd0);
        chk("rst_resp_ready", 32'(lsu_resp_ready_o), 32'd1);
        chk("rst_busy", 32'(busy_o), 32'd0);
        rst = 1'b0;
        tick;
        chk("post_rst_busy", 32'(busy_o), 32'd0);
        chk("post_rst_resp_ready", 32'(lsu_resp_ready_o), 32'd1);

        // alternating grants until the tag FIFO is full
        req_valid_i = 2'b11; lsu_req_ready_i = 1'b1; resp_ready_i = 2'b11; #1;
        chk("rr0_valid", 32'(lsu_req_valid_o), 32'd1);
        chk("rr0_data", 32'(lsu_req_o), 32'(R0));
        chk("rr0_ready", 32'(req_ready_o), 32'b01);
        tick;
        chk("rr1_data", 32'(lsu_req_o), 32'(R1));
        chk("rr1_ready", 32'(req_ready_o), 32'b10);
        tick;
        chk("rr2_ready", 32'(req_ready_o), 32'b01);
        tick;
        chk("rr3_ready", 32'(req_ready_o), 32'b10);
        tick;
        chk("full_valid", 32'(lsu_req_valid_o), 32'd0);
        chk("full_ready", 32'(req_ready_o), 32'd0);
        chk("full_busy", 32'(busy_o), 32'd1);
        lsu_resp_valid_i = 1'b1; lsu_resp_i = 17'h1_1111; #1;
        chk("full_pop_route", 32'(resp_valid_o), 32'b01);
        chk("full_pop_data", 32'(resp_o), 32'h1_1111);
        chk("full_pop_ready", 32'(lsu_resp_ready_o), 32'd1);
        tick;
        lsu_resp_valid_i = 1'b0; #1;
        chk("resume_valid", 32'(lsu_req_valid_o), 32'd1);
        chk("resume_ready", 32'(req_ready_o), 32'b01);
        tick;

        // FIFO now holds 1,0,1,0; head requester 1 stalls
        req_valid_i = 2'b00; lsu_req_ready_i = 1'b0;
        lsu_resp_valid_i = 1'b1; resp_ready_i = 2'b01; #1;
        chk("bp_lsu_ready", 32'(lsu_resp_ready_o), 32'd0);
        chk("bp_route", 32'(resp_valid_o), 32'b10);
        tick;
        chk("bp_not_popped", 32'(resp_valid_o), 32'b10);
        resp_ready_i = 2'b11; #1;
        chk("bp_release", 32'(lsu_resp_ready_o), 32'd1);
        tick;
        chk("drain_r0", 32'(resp_valid_o), 32'b01);
        tick;
        chk("drain_r1", 32'(resp_valid_o), 32'b10);
        tick;
        chk("drain_r0b", 32'(resp_valid_o), 32'b01);
        tick;
        chk("empty_sink_valid", 32'(resp_valid_o), 32'b00);
        chk("empty_sink_ready", 32'(lsu_resp_ready_o), 32'd1);
        chk("empty_busy", 32'(busy_o), 32'd0);
        lsu_resp_valid_i = 1'b0;

        // rr_q=1: requester 0 stalls alone, then requester 1 joins
        req_valid_i = 2'b01; lsu_req_ready_i = 1'b0; #1;
        chk("hold_data0", 32'(lsu_req_o), 32'(R0));
        chk("hold_ready0", 32'(req_ready_o), 32'b00);
        tick; tick; tick;
        req_valid_i = 2'b11; #1;
        chk("hold_keep_data", 32'(lsu_req_o), 32'(R0));
        chk("hold_keep_valid", 32'(lsu_req_valid_o), 32'd1);
        lsu_req_ready_i = 1'b1; #1;
        chk("hold_hs_ready", 32'(req_ready_o), 32'b01);
        tick;
        chk("hold_next_data", 32'(lsu_req_o), 32'(R1));
        chk("hold_next_ready", 32'(req_ready_o), 32'b10);
        tick;
        req_valid_i = 2'b00; lsu_req_ready_i = 1'b0; lsu_resp_valid_i = 1'b1; #1;
        chk("hold_resp0", 32'(resp_valid_o), 32'b01);
        tick;
        chk("hold_resp1", 32'(resp_valid_o), 32'b10);
        tick;
        lsu_resp_valid_i = 1'b0;

        // two loads from requester 0, then a barrier from requester 1
        req_valid_i = 2'b01; lsu_req_ready_i = 1'b1; #1;
        chk("ld0_data", 32'(lsu_req_o), 32'(R0));
        tick;
        chk("ld1_data", 32'(lsu_req_o), 32'(R0));
        tick;
        req_i = {R1B, R0}; req_valid_i = 2'b10; #1;
        chk("dbar_data", 32'(lsu_req_o), 32'(R1B));
        chk("dbar_valid", 32'(lsu_req_valid_o), 32'd1);
        tick;
        req_valid_i = 2'b11; #1;
        chk("drain_blocked", 32'(lsu_req_valid_o), 32'd0);
        chk("drain_busy", 32'(busy_o), 32'd1);
        lsu_resp_valid_i = 1'b1; #1;
        chk("drain_pop0", 32'(resp_valid_o), 32'b01);
        tick;
        chk("drain_blocked1", 32'(lsu_req_valid_o), 32'd0);
        chk("drain_pop1", 32'(resp_valid_o), 32'b01);
        tick;
        chk("drain_blocked2", 32'(lsu_req_valid_o), 32'd0);
        chk("drain_pop2", 32'(resp_valid_o), 32'b10);
        tick;
        lsu_resp_valid_i = 1'b0; req_i = {R1, R0}; #1;
        chk("drain_resume", 32'(lsu_req_valid_o), 32'd1);
        chk("drain_resume_data", 32'(lsu_req_o), 32'(R0));
        req_valid_i = 2'b00;
        tick;

        // three in flight, then flush with a response arriving
        req_valid_i = 2'b11; lsu_req_ready_i = 1'b1;
        tick; tick; tick;
        flush_i = 1'b1; lsu_resp_valid_i = 1'b1; #1;
        chk("flush_resp_valid", 32'(resp_valid_o), 32'b00);
        chk("flush_req_valid", 32'(lsu_req_valid_o), 32'd0);
        chk("flush_req_ready", 32'(req_ready_o), 32'b00);
        tick;
        flush_i = 1'b0; req_valid_i = 2'b00; resp_ready_i = 2'b00; #1;
        chk("flush_busy", 32'(busy_o), 32'd0);
        for (int i = 0; i < 3; i++) begin
            chk("stale_ready", 32'(lsu_resp_ready_o), 32'd1);
            chk("stale_valid", 32'(resp_valid_o), 32'b00);
            tick;
        end
        lsu_resp_valid_i = 1'b0; req_valid_i = 2'b11; lsu_req_ready_i = 1'b0; #1;
        chk("flush_rr_reset", 32'(lsu_req_o), 32'(R0));
        chk("final_busy", 32'(busy_o), 32'd0);
        req_valid_i = 2'b00;
        tick;

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
